pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//  WIDTH-bit add/subtract unit built from 4-bit carry-lookahead slices and split into STAGES register stages.
//  Each stage resolves WIDTH/STAGES bits and registers the inter-stage carry.
//  Valid/ready handshake on both sides; sits between the ALU operand muxes and the writeback path.
//  Successor of the single-cycle 4-bit CLA: parametrised width, pipelined, subtract mode, back-pressure.
// PARAMETERS
//  WIDTH   32  operand/result width; multiple of 4
//  STAGES  2   pipeline stages, >=1; (WIDTH/4) % STAGES == 0; CHUNK = WIDTH/STAGES
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands presented
//  in_ready   out  1      unit accepts this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      1: A - B (two's complement); 0: A + B
//  in_cin     in   1      carry-in for add; ignored when in_sub=1
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result, modulo 2^WIDTH
//  out_cout   out  1      carry out of MSB (sub: 1 = no borrow)
//  out_zero   out  1      [ADDER_FLAGS_EN only] out_sum == 0
//  out_neg    out  1      [ADDER_FLAGS_EN only] out_sum[WIDTH-1]
//  out_ovf    out  1      [ADDER_FLAGS_EN only] signed overflow
// BEHAVIOUR
//  - Function: {cout,sum} = A + (sub ? ~B : B) + (sub ? 1 : cin); unsigned WIDTH+1-bit result.
//  - Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] from the registered carry of stage k-1.
//    Stage 0 uses the effective carry-in. CHUNK/4 slices ripple combinationally within a stage.
//  - Unprocessed upper operand bits and finished lower sum bits travel in skew registers alongside.
//  - Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no stall.
//  - Throughput: one operation per cycle while out_ready=1.
//  - Stall: global enable en = !out_valid | out_ready; in_ready = en.
//    All stage registers and valids advance only when en=1.
//    When out_valid=1 and out_ready=0, out_* are held stable until accepted.
//  - Bubbles: a stage valid=0 carries no data; its data registers may hold stale values. Outputs are only meaningful when out_valid=1.
//  - Accept and drain in the same cycle is legal: results stay in order, none lost or duplicated.
//  - Reset (any cycle, mid-flight too): all stage valids=0, out_valid=0, out_sum=0, out_cout=0, flags=0.
//    In-flight operations are discarded. in_ready=1 in the first cycle after reset.
//  - Wrap-around: FFFF_FFFF + 1 -> sum 0, cout 1. 0 - 1 -> sum FFFF_FFFF, cout 0.
//  - STAGES=1: purely combinational CLA chain with a single output register; latency 1.
// CONFIGURATION
//  ADDER_FLAGS_EN defined:
//    out_zero/out_neg/out_ovf exist and are registered with out_sum.
//    ovf = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]), where B' is the effective (possibly inverted) B.
//  ADDER_FLAGS_EN undefined: the three ports and their logic are absent; all else identical.
// STRUCTURE
//  Shared package/header (adder_defs.vh): SLICE_W=4 localparam and OP_ADD=1'b0 / OP_SUB=1'b1.
//  Sub-module cla_slice4: combinational 4-bit slice with generate/propagate (G=A&B, P=A|B).
//    Ports a[3:0], b[3:0], cin -> s[3:0], cout.
//  Top instantiates WIDTH/4 slices via generate and places stage registers every CHUNK/4 slices.
// TESTING
//  1. WIDTH=32 STAGES=2: A=0000_0005 B=0000_0003 sub=0 cin=0 -> sum 0000_0008, cout 0, out_valid 2 cycles after accept.
//  2. Add FFFF_FFFF+0000_0001 -> sum 0, cout 1. Sub 0-1 -> sum FFFF_FFFF, cout 0. Sub 7-7 -> sum 0, cout 1.
//  3. Back-to-back: 8 ops issued on consecutive cycles, out_ready=1 -> 8 results on consecutive cycles, in order.
//  4. Hold out_ready=0 for 5 cycles with 2 ops in flight -> in_ready=0 after pipe fills; out_sum stable; release -> both delivered, none lost.
//  5. Assert rst while 2 ops are in flight -> next cycle out_valid=0, out_sum=0, in_ready=1; no stale result appears.
//  6. ADDER_FLAGS_EN: 7FFF_FFFF+1 -> ovf 1, neg 1, zero 0. 8000_0000-1 -> ovf 1, neg 0. Repeat random 10k vs golden model at STAGES=1,2,4,8.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and small helpers for the pipelined carry-lookahead adder.
// Optional status flags are enabled with the ADDER_FLAGS_EN macro.
package pipelined_cla_adder_pkg;

  localparam int   SLICE_W = 4;
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;

  // Subtract is A + ~B + 1, so the external carry-in only matters for add.
  function automatic logic eff_cin(input logic sub, input logic cin);
    return (sub == OP_SUB) ? 1'b1 : cin;
  endfunction

  function automatic logic [SLICE_W-1:0] eff_b_nibble_unused(input logic [SLICE_W-1:0] b);
    return b;
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_slice.sv
// Combinational 4-bit carry-lookahead slice (G = A & B, P = A | B).
// Building block of pipelined_cla_adder; see that file for ADDER_FLAGS_EN.
module cla_slice4
  import pipelined_cla_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] g_s;
  logic [SLICE_W-1:0] p_s;
  logic [SLICE_W-1:0] c_s;

  // Two-level lookahead carries for all four bit positions and the slice carry-out.
  always_comb begin
    g_s    = a & b;
    p_s    = a | b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    cout   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    s      = a ^ b ^ c_s;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/subtract unit, CLA slices split into STAGES registered stages with valid/ready.
// Define ADDER_FLAGS_EN to add registered zero/negative/signed-overflow flags.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADDER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int SPS   = CHUNK / SLICE_W;

  logic en_s;
  logic out_valid_s;

  // One global enable: the whole pipe moves unless a finished result is blocked.
  always_comb begin
    en_s = !out_valid_s || out_ready;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // REM operand bits still unprocessed on entry; DONE sum bits finished on exit.
    localparam int REM  = WIDTH - k * CHUNK;
    localparam int DONE = (k + 1) * CHUNK;

    logic [REM-1:0]   a_in_s;
    logic [REM-1:0]   b_in_s;
    logic             cin_in_s;
    logic             valid_in_s;
    logic [CHUNK-1:0] chunk_sum_s;
    logic [DONE-1:0]  sum_d;
    logic [DONE-1:0]  sum_q;
    logic             carry_d;
    logic             carry_q;
    logic             valid_d;
    logic             valid_q;

    if (k == 0) begin : g_head
      assign a_in_s     = in_a;
      assign b_in_s     = (in_sub == OP_SUB) ? ~in_b : in_b;
      assign cin_in_s   = eff_cin(in_sub, in_cin);
      assign valid_in_s = in_valid;
    end else begin : g_tail
      assign a_in_s     = g_stage[k-1].g_skew.a_q;
      assign b_in_s     = g_stage[k-1].g_skew.b_q;
      assign cin_in_s   = g_stage[k-1].carry_q;
      assign valid_in_s = g_stage[k-1].valid_q;
    end

    for (genvar s = 0; s < SPS; s++) begin : g_slice
      logic cin_s;
      logic cout_s;

      if (s == 0) begin : g_first
        assign cin_s = cin_in_s;
      end else begin : g_chain
        assign cin_s = g_slice[s-1].cout_s;
      end

      cla_slice4 u_slice (
        .a    (a_in_s[s*SLICE_W +: SLICE_W]),
        .b    (b_in_s[s*SLICE_W +: SLICE_W]),
        .cin  (cin_s),
        .s    (chunk_sum_s[s*SLICE_W +: SLICE_W]),
        .cout (cout_s)
      );
    end

    if (k == 0) begin : g_sum_head
      // First stage has no lower sum bits to carry along.
      always_comb begin
        sum_d = chunk_sum_s;
      end
    end else begin : g_sum_tail
      // Append this chunk above the lower sum bits finished upstream.
      always_comb begin
        sum_d = {chunk_sum_s, g_stage[k-1].sum_q};
      end
    end

    // Stage carry-out and valid feed the next stage register.
    always_comb begin
      carry_d = g_slice[SPS-1].cout_s;
      valid_d = valid_in_s;
    end

    // Stage register: cleared by reset, otherwise advances only with the global enable.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q   <= {DONE{1'b0}};
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else if (en_s) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end else begin
        sum_q   <= sum_q;
        carry_q <= carry_q;
        valid_q <= valid_q;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_d;
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_d;
      logic [REM-CHUNK-1:0] b_q;

      // Upper operand bits not yet consumed travel to the next stage.
      always_comb begin
        a_d = a_in_s[REM-1:CHUNK];
        b_d = b_in_s[REM-1:CHUNK];
      end

      // Operand skew register, same enable and reset as the stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= {(REM-CHUNK){1'b0}};
          b_q <= {(REM-CHUNK){1'b0}};
        end else if (en_s) begin
          a_q <= a_d;
          b_q <= b_d;
        end else begin
          a_q <= a_q;
          b_q <= b_q;
        end
      end
    end
  end

  assign out_valid_s = g_stage[STAGES-1].valid_q;
  assign out_valid   = out_valid_s;
  assign out_sum     = g_stage[STAGES-1].sum_q;
  assign out_cout    = g_stage[STAGES-1].carry_q;
  assign in_ready    = en_s;

`ifdef ADDER_FLAGS_EN
  logic zero_d;
  logic zero_q;
  logic neg_d;
  logic neg_q;
  logic ovf_d;
  logic ovf_q;

  // Flags derive from the final stage's full sum and the operand MSBs it consumes.
  always_comb begin
    zero_d = (g_stage[STAGES-1].sum_d == {WIDTH{1'b0}});
    neg_d  = g_stage[STAGES-1].sum_d[WIDTH-1];
    ovf_d  = signed_ovf(g_stage[STAGES-1].a_in_s[CHUNK-1],
                        g_stage[STAGES-1].b_in_s[CHUNK-1],
                        g_stage[STAGES-1].sum_d[WIDTH-1]);
  end

  // Flag register moves in lockstep with the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en_s) begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end else begin
      zero_q <= zero_q;
      neg_q  <= neg_q;
      ovf_q  <= ovf_q;
    end
  end

  assign out_zero = zero_q;
  assign out_neg  = neg_q;
  assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder (WIDTH=32, STAGES=2).
// Flag checks are compiled in when ADDER_FLAGS_EN is defined.
module tb_pipelined_cla_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef ADDER_FLAGS_EN
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ADDER_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [31:0] bb;
    logic        c;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, bb} + {32'd0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready=1, wait (bounded) for its result and check it.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin,
                       input logic [31:0] exp_sum, input logic exp_cout);
    int cnt;
    out_ready = 1'b1;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 64'(cnt), 64'(STAGES - 1));
    chk({tag, "_sum"}, {32'd0, out_sum}, {32'd0, exp_sum});
    chk({tag, "_cout"}, {63'd0, out_cout}, {63'd0, exp_cout});
  endtask

  initial begin
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic        ts [8];
    logic [32:0] te [8];
    logic [32:0] r;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic        rc;

    rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
    in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
    chk("rst_out_cout", {63'd0, out_cout}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    tick();

    do_op("add_5_3", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0);
    do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    do_op("sub_0_1", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    do_op("sub_7_7", 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    do_op("add_cin", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0003, 1'b0);
    do_op("sub_cin_ign", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0007, 1'b1);
    do_op("chunk_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0);
    do_op("msb_carry", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);

`ifdef ADDER_FLAGS_EN
    do_op("fl_add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
    chk("fl_add_ovf_ovf", {63'd0, out_ovf}, 64'd1);
    chk("fl_add_ovf_neg", {63'd0, out_neg}, 64'd1);
    chk("fl_add_ovf_zero", {63'd0, out_zero}, 64'd0);
    do_op("fl_sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
    chk("fl_sub_ovf_ovf", {63'd0, out_ovf}, 64'd1);
    chk("fl_sub_ovf_neg", {63'd0, out_neg}, 64'd0);
    do_op("fl_zero", 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    chk("fl_zero_zero", {63'd0, out_zero}, 64'd1);
    chk("fl_zero_ovf", {63'd0, out_ovf}, 64'd0);
`endif

    // Back-to-back: 8 ops on consecutive cycles, results on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      ta[i] = 32'h1357_9BDF * i + 32'hFFFF_0000;
      tb[i] = 32'h0000_FFFF + i;
      ts[i] = (i % 2) == 1;
      te[i] = model(ta[i], tb[i], ts[i], 1'b0);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_a = ta[c]; in_b = tb[c]; in_sub = ts[c]; in_cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 8) begin
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_sum", {31'd0, out_cout, out_sum}, {31'd0, te[c-1]});
      end else begin
        chk("b2b_idle", {63'd0, out_valid}, 64'd0);
      end
    end

    // Stall with two ops in flight, a third op waiting at the input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd23; in_sub = 1'b0;
    tick();
    in_a = 32'd50; in_b = 32'd8; in_sub = 1'b1;
    tick();
    in_a = 32'd1; in_b = 32'd2; in_sub = 1'b0;
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_sum", {32'd0, out_sum}, 64'd123);
      chk("stall_in_ready_hold", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("drain_b_valid", {63'd0, out_valid}, 64'd1);
    chk("drain_b_sum", {31'd0, out_cout, out_sum}, {31'd0, 1'b1, 32'd42});
    tick();
    chk("drain_c_valid", {63'd0, out_valid}, 64'd1);
    chk("drain_c_sum", {32'd0, out_sum}, 64'd3);
    tick();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // Reset with two ops in flight: both must be discarded.
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; in_sub = 1'b0;
    tick();
    in_a = 32'd9; in_b = 32'd9;
    tick();
    chk("pre_rst_sum", {32'd0, out_sum}, 64'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_sum", {32'd0, out_sum}, 64'd0);
    chk("mid_rst_cout", {63'd0, out_cout}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // Random ops against the arithmetic definition.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      r  = model(ra, rb, rs, rc);
      do_op("rand", ra, rb, rs, rc, r[31:0], r[32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
